// File: rtl/imem_fetch_ctrl_pkg.sv
// ============================================================================
// Module   : imem_fetch_ctrl_pkg
// Purpose  : Shared types and constants for the instruction fetch controller.
//            The word and instruction widths mirror the core-wide WORD and
//            INSTR_LEN definitions (32 bits each).
// Contents : fetch_state_t (BOOT/RUN/HALT, 2-bit), INSTR_BYTES, wrap_addr().
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_fetch_ctrl_pkg;

    localparam int WORD_W      = 32;
    localparam int INSTR_LEN   = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // Reduce a byte address modulo a power-of-two memory size.
    function automatic logic [WORD_W-1:0] wrap_addr(
        input logic [WORD_W-1:0] addr,
        input logic [WORD_W-1:0] size
    );
        return addr & (size - 1'b1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_fetch_ctrl_fetch_hold_reg.sv
// ============================================================================
// Module   : imem_fetch_ctrl_fetch_hold_reg
// Purpose  : One-entry hold (skid) register between the instruction memory
//            read port and the decode handshake. When the word currently
//            arriving from memory is not accepted, it is parked here and
//            presented until decode takes it.
// Ports    : clk, rst_n      - clock, async active-low reset
//            flush           - discard parked word (redirect/halt)
//            in_valid/data/pc- word arriving from memory this cycle
//            out_ready       - decode accepts
//            out_valid/data/pc - word presented to decode
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_fetch_ctrl_fetch_hold_reg
    import imem_fetch_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [INSTR_LEN-1:0] in_data,
    input  logic [WORD_W-1:0]    in_pc,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [INSTR_LEN-1:0] out_data,
    output logic [WORD_W-1:0]    out_pc
);

    logic                 hold_valid;
    logic [INSTR_LEN-1:0] hold_data;
    logic [WORD_W-1:0]    hold_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_pc    <= '0;
        end else if (flush) begin
            hold_valid <= 1'b0;
        end else if (hold_valid) begin
            if (out_ready) begin
                hold_valid <= 1'b0;
            end
        end else if (in_valid && !out_ready) begin
            hold_valid <= 1'b1;
            hold_data  <= in_data;
            hold_pc    <= in_pc;
        end
    end

    // While a word is parked, the memory keeps re-reading the stalled PC, so
    // the live input is a duplicate of what comes next and is ignored.
    // Outputs are forced to zero when nothing is valid.
    assign out_valid = hold_valid | in_valid;
    assign out_data  = hold_valid ? hold_data : (in_valid ? in_data : '0);
    assign out_pc    = hold_valid ? hold_pc   : (in_valid ? in_pc   : '0);

endmodule

`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
// ============================================================================
// Module   : imem_fetch_ctrl
// Purpose  : Sequencer for the single-port word-addressed instruction memory.
//            BOOT : streams loader words into memory from RESET_PC upward.
//            RUN  : issues sequential fetches, presents instructions to decode
//                   with valid/ready, handles redirect, stall and halt.
//            HALT : fetch frozen; ld_start re-enters BOOT.
// Params   : RESET_PC (byte addr), MEM_BYTES (power of two), BOOT_LOAD.
// Ports    : ld_*        - loader stream (valid/ready, last)
//            mem_*       - memory port (1-cycle registered read latency)
//            instr_*     - decode interface; fetch_ready from decode
//            branch_*    - redirect pulse and target
//            halt_req    - stop fetching; state_o - debug state
// Option   : IMEM_ALIGN_CHECK_EN adds sticky output misalign_err; a branch
//            to a non-word-aligned target halts instead of redirecting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = '0,
    parameter int                MEM_BYTES = 4096,
    parameter bit                BOOT_LOAD = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ld_start,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [INSTR_LEN-1:0] ld_data,
    input  logic                 ld_last,
    output logic [WORD_W-1:0]    mem_address,
    output logic                 mem_we,
    output logic [INSTR_LEN-1:0] mem_wdata,
    input  logic [INSTR_LEN-1:0] mem_instruction,
    output logic                 instr_valid,
    input  logic                 fetch_ready,
    output logic [INSTR_LEN-1:0] instr,
    output logic [WORD_W-1:0]    instr_pc,
    input  logic                 branch_taken,
    input  logic [WORD_W-1:0]    branch_target,
    input  logic                 halt_req,
`ifdef IMEM_ALIGN_CHECK_EN
    output logic                 misalign_err,
`endif
    output logic [1:0]           state_o
);

    localparam logic [WORD_W-1:0] MEM_SIZE  = WORD_W'(MEM_BYTES);
    localparam logic [WORD_W-1:0] STEP      = WORD_W'(INSTR_BYTES);
    localparam logic [WORD_W-1:0] LOW_MASK  = ~WORD_W'(3);
    localparam logic [WORD_W-1:0] START_PC  = wrap_addr(RESET_PC, MEM_SIZE);
    localparam fetch_state_t      RST_STATE = BOOT_LOAD ? ST_BOOT : ST_RUN;

    fetch_state_t      state, state_next;
    logic [WORD_W-1:0] pc, pc_next;
    logic [WORD_W-1:0] load_addr, load_addr_next;
    logic              fl_valid, fl_valid_next;   // address issued last cycle
    logic [WORD_W-1:0] fl_pc;                     // ... and its value
    logic              flush;
    logic [WORD_W-1:0] target;
    logic              target_bad;

`ifdef IMEM_ALIGN_CHECK_EN
    assign target     = wrap_addr(branch_target, MEM_SIZE);
    assign target_bad = |branch_target[1:0];
`else
    assign target     = wrap_addr(branch_target, MEM_SIZE) & LOW_MASK;
    assign target_bad = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_STATE;
            pc        <= START_PC;
            load_addr <= START_PC;
            fl_valid  <= 1'b0;
            fl_pc     <= '0;
            ld_ready  <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            load_addr <= load_addr_next;
            fl_valid  <= fl_valid_next;
            fl_pc     <= pc;
            // Registered so it rises the cycle after reset release / BOOT entry.
            ld_ready  <= (state_next == ST_BOOT);
        end
    end

`ifdef IMEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (state == ST_RUN && !halt_req && branch_taken && target_bad) begin
            misalign_err <= 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic. Priority in RUN: halt > branch > stall.
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        pc_next        = pc;
        load_addr_next = load_addr;
        fl_valid_next  = 1'b0;
        flush          = 1'b0;
        case (state)
            ST_BOOT: begin
                flush = 1'b1;
                if (ld_valid && ld_ready) begin
                    load_addr_next = wrap_addr(load_addr + STEP, MEM_SIZE);
                    // Last word, or wrapped all the way round (memory full).
                    if (ld_last || load_addr_next == START_PC) begin
                        state_next = ST_RUN;
                        pc_next    = START_PC;
                    end
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_next = ST_HALT;
                    flush      = 1'b1;
                end else if (branch_taken && target_bad) begin
                    state_next = ST_HALT;
                    flush      = 1'b1;
                end else if (branch_taken) begin
                    pc_next = target;
                    flush   = 1'b1;
                end else begin
                    // During a stall the PC holds, so memory re-reads the same
                    // word each cycle and nothing is lost behind the hold entry.
                    fl_valid_next = 1'b1;
                    if (!instr_valid || fetch_ready) begin
                        pc_next = wrap_addr(pc + STEP, MEM_SIZE);
                    end
                end
            end
            ST_HALT: begin
                flush = 1'b1;
                if (ld_start) begin
                    state_next     = ST_BOOT;
                    load_addr_next = START_PC;
                end
            end
            default: begin
                state_next = ST_HALT;
                flush      = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Memory port
    // ------------------------------------------------------------------
    assign mem_address = (state == ST_BOOT) ? load_addr : pc;
    assign mem_we      = (state == ST_BOOT) & ld_valid & ld_ready;
    assign mem_wdata   = ((state == ST_BOOT) && ld_ready) ? ld_data : '0;
    assign state_o     = state;

    // ------------------------------------------------------------------
    // Decode-side hold register
    // ------------------------------------------------------------------
    imem_fetch_ctrl_fetch_hold_reg u_fetch_hold_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (fl_valid),
        .in_data   (mem_instruction),
        .in_pc     (fl_pc),
        .out_ready (fetch_ready),
        .out_valid (instr_valid),
        .out_data  (instr),
        .out_pc    (instr_pc)
    );

endmodule

`default_nettype wire

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Sequencer for the single-port, word-addressed instruction memory. It owns the program counter and has two jobs:
- Boot: arbitrates the memory port to a program-loader stream, writing instruction words from RESET_PC upward.
- Run: issues sequential fetch addresses, delivers instructions to the decode stage with a valid/ready handshake, and handles branch redirect, stall and halt.
It sits between instruction_mem and the core's decode stage.

Parameters:
RESET_PC, 0, byte address of the first fetch and the first load word.
MEM_BYTES, 4096, instruction memory size in bytes (power of two, multiple of 4). PC arithmetic is modulo MEM_BYTES.
BOOT_LOAD, 1, 1 = enter BOOT after reset; 0 = enter RUN directly.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ld_start  in  1  request reload; honoured in HALT only
ld_valid  in  1  loader word valid
ld_ready  out  1  controller accepts loader word
ld_data  in  `INSTR_LEN  loader instruction word
ld_last  in  1  qualifies final loader word
mem_address  out  `WORD  byte address to instruction_mem
mem_we  out  1  memory write enable
mem_wdata  out  `INSTR_LEN  memory write data
mem_instruction  in  `INSTR_LEN  memory read data; 1-cycle registered latency
instr_valid  out  1  instr/instr_pc valid to decode
fetch_ready  in  1  decode accepts instruction
instr  out  `INSTR_LEN  fetched instruction
instr_pc  out  `WORD  address of instr
branch_taken  in  1  redirect pulse
branch_target  in  `WORD  redirect byte address
halt_req  in  1  stop fetching
state_o  out  2  current state, for debug

Behaviour:
- Reset (async, rst_n=0) forces these values:
  - state = BOOT if BOOT_LOAD, else RUN.
  - pc = load_addr = RESET_PC; mem_address = RESET_PC.
  - mem_we = 0; mem_wdata = 0; ld_ready = 0; instr_valid = 0; instr = 0; instr_pc = 0.
  - Any partial load is discarded; the in-flight fetch is squashed.
- States: BOOT(0), RUN(1), HALT(2).
- BOOT:
  - ld_ready = 1, starting the cycle after reset release.
  - mem_address = load_addr; mem_we = ld_valid & ld_ready; mem_wdata = ld_data (all combinational).
  - Each accepted word: load_addr += 4.
  - Transition to RUN when ld_last is accepted or load_addr wraps back to RESET_PC (memory full). On transition: ld_ready drops, pc = RESET_PC.
  - instr_valid = 0 throughout BOOT.
- RUN, memory interface: mem_we = 0; mem_address = pc.
- RUN, fetch latency: address issued in cycle n produces instr_valid in cycle n+1, with instr_pc = that address.
- RUN, normal advance: on (!instr_valid | fetch_ready), pc += 4 mod MEM_BYTES each cycle.
- RUN, stall: instr_valid & !fetch_ready holds instr, instr_pc, instr_valid and pc stable.
  - A 1-entry hold register captures mem_instruction.
  - No instruction is lost or duplicated.
- RUN, redirect: branch_taken in cycle n has priority over stall.
  - pc = branch_target in cycle n+1.
  - instr_valid = 0 in cycle n+1, squashing the in-flight word.
  - First target instruction is valid in cycle n+2.
- HALT entry: halt_req in RUN moves to HALT next cycle. The currently presented valid instruction is squashed; pc is frozen.
- HALT: instr_valid = 0; mem_we = 0. ld_start moves to BOOT with load_addr = RESET_PC. branch_taken is ignored.
- Simultaneous events in RUN: halt_req beats branch_taken, which beats stall.
- ld_start outside HALT is ignored.
- Width rules:
  - branch_target is used modulo MEM_BYTES.
  - Bits [1:0] are forced to 0 unless the optional feature is enabled.

Optional Feature:
IMEM_ALIGN_CHECK_EN
- Defined: adds output misalign_err (1 bit, reset 0), a sticky flag set when branch_taken carries branch_target[1:0] != 0. The controller enters HALT instead of redirecting. misalign_err clears only on reset.
- Undefined: no port; low bits are silently masked.

Decomposition:
- Shared package: fetch state enum (BOOT/RUN/HALT, 2-bit), INSTR_BYTES = 4 constant.
- Existing `WORD and `INSTR_LEN come from constants.vh.
- One natural sub-module: fetch_hold_reg, the 1-entry skid/hold register with valid/ready.

Test Plan:
- BOOT_LOAD=1, load words 0..7 with ld_last on word 7 -> mem_we pulses at addresses 0,4,...,28; RUN entered; instr_valid on consecutive cycles with instr = 0..7 and instr_pc = 0,4,...,28.
- fetch_ready=0 for 3 cycles while instr_pc=8 -> instr and instr_pc hold at 8 for 3 cycles; next accepted instr_pc = 12, no gap, no duplicate.
- branch_taken with branch_target=0x40 while instr_pc=16 -> next cycle instr_valid=0; following cycle instr_pc = 0x40.
- MEM_BYTES=64, run sequentially -> after instr_pc=60 the next instr_pc = 0.
- rst_n low after 3 loader words -> all outputs at reset values immediately; reload restarts at RESET_PC.
- With IMEM_ALIGN_CHECK_EN, branch_target=0x42 -> misalign_err=1, state_o=HALT, instr_valid=0; then ld_start -> BOOT.
